hit_judge: RTL and testbench

- Downstream consumer of the receptor stage's per-lane key_press strobes (lanes 0..3 = left, down, up, right).
- key_press is only high while the beam scans a receptor, so this block ORs it over each video frame.
- At each frame boundary it detects new presses and judges them against the nearest note Y position per lane from the note engine.
- Outputs: per-lane judgement events, note-clear pulses, score, combo and max-combo registers for the HUD.

---
 rtl/hit_judge_if.sv | 24 ++
 rtl/hit_judge.sv | 108 ++++++++++
 tb/tb_hit_judge.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hit_judge_if.sv
// hit_judge_if: note engine, receptor and HUD signals of the hit judge.
interface hit_judge_if;
    logic        frame_clk;
    logic [3:0]  key_press;
    logic [3:0]  note_valid;
    logic [39:0] note_y;
    logic [3:0]  note_clear;
    logic        judge_valid;
    logic [1:0]  judgement;
    logic [1:0]  judge_lane;
    logic [15:0] score;
    logic [9:0]  combo;
    logic [9:0]  max_combo;
    logic        busy;
    logic        overrun;
    modport slave (
        input  frame_clk, key_press, note_valid, note_y,
        output note_clear, judge_valid, judgement, judge_lane, score, combo, max_combo, busy, overrun
    );
    modport master (
        output frame_clk, key_press, note_valid, note_y,
        input  note_clear, judge_valid, judgement, judge_lane, score, combo, max_combo, busy, overrun
    );
endinterface

// File: rtl/hit_judge.sv
// hit_judge: per-frame press capture and lane-by-lane timing judgement with score/combo tracking.
module hit_judge #(
    parameter int TARGET_Y    = 54,
    parameter int PERFECT_WIN = 4,
    parameter int GOOD_WIN    = 12,
    parameter int PERFECT_PTS = 2,
    parameter int GOOD_PTS    = 1
) (
    input logic     Clk,
    input logic     Reset,
    hit_judge_if.slave bus
);
    typedef enum logic {IDLE, EVAL} state_t;
    state_t      state_q, state_d;
    logic        frame_q, frame_d;
    logic [3:0]  acc_q, acc_d;
    logic [3:0]  held_q, held_d;
    logic [3:0]  newpress_q, newpress_d;
    logic [1:0]  lane_q, lane_d;
    logic [3:0]  note_clear_q, note_clear_d;
    logic        judge_valid_q, judge_valid_d;
    logic [1:0]  judgement_q, judgement_d;
    logic [1:0]  judge_lane_q, judge_lane_d;
    logic [15:0] score_q, score_d;
    logic [9:0]  combo_q, combo_d;
    logic [9:0]  max_combo_q, max_combo_d;
    logic        overrun_q, overrun_d;
    logic        tick, accept, eval, miss, perfect, good, ev, hit;
    logic [9:0]  y;
    logic signed [10:0] diff;
    logic [10:0] ad;
    logic [1:0]  jd;
    logic [15:0] pts;
    logic [16:0] sum;
    always_comb begin
        tick    = bus.frame_clk & ~frame_q;
        eval    = state_q == EVAL;
        accept  = tick & ~eval;
        y       = bus.note_y[5'(lane_q) * 5'd10 +: 10];
        diff    = $signed({1'b0, y}) - $signed(11'(TARGET_Y));
        ad      = diff[10] ? 11'(-diff) : 11'(diff);
        // a note that has scrolled past the good window is missed whether pressed or not
        miss    = bus.note_valid[lane_q] && ({1'b0, y} + 11'(GOOD_WIN) < 11'(TARGET_Y));
        perfect = newpress_q[lane_q] && bus.note_valid[lane_q] && ad <= 11'(PERFECT_WIN);
        good    = newpress_q[lane_q] && bus.note_valid[lane_q] && ad <= 11'(GOOD_WIN);
        jd      = !eval ? 2'd0 : miss ? 2'd3 : perfect ? 2'd1 : good ? 2'd2 : 2'd0;
        ev      = jd != 2'd0;
        hit     = jd == 2'd1 || jd == 2'd2;
        pts     = jd == 2'd1 ? 16'(PERFECT_PTS) : 16'(GOOD_PTS);
        sum     = {1'b0, score_q} + {1'b0, pts};
        frame_d       = bus.frame_clk;
        acc_d         = accept ? bus.key_press : acc_q | bus.key_press;
        held_d        = accept ? acc_q : held_q;
        newpress_d    = accept ? acc_q & ~held_q : newpress_q;
        state_d       = accept ? EVAL : (eval && lane_q == 2'd3) ? IDLE : state_q;
        lane_d        = accept ? 2'd0 : eval ? lane_q + 2'd1 : lane_q;
        overrun_d     = overrun_q | (tick & eval);
        judge_valid_d = ev;
        note_clear_d  = ev ? 4'b0001 << lane_q : 4'b0000;
        judgement_d   = ev ? jd : judgement_q;
        judge_lane_d  = ev ? lane_q : judge_lane_q;
        score_d       = !hit ? score_q : sum[16] ? 16'hFFFF : sum[15:0];
        combo_d       = jd == 2'd3 ? 10'd0 : !hit ? combo_q : combo_q == 10'd1023 ? combo_q : combo_q + 10'd1;
        max_combo_d   = combo_d > max_combo_q ? combo_d : max_combo_q;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            frame_q       <= 1'b0;
            acc_q         <= '0;
            held_q        <= '0;
            newpress_q    <= '0;
            lane_q        <= '0;
            note_clear_q  <= '0;
            judge_valid_q <= 1'b0;
            judgement_q   <= '0;
            judge_lane_q  <= '0;
            score_q       <= '0;
            combo_q       <= '0;
            max_combo_q   <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            acc_q         <= acc_d;
            held_q        <= held_d;
            newpress_q    <= newpress_d;
            lane_q        <= lane_d;
            note_clear_q  <= note_clear_d;
            judge_valid_q <= judge_valid_d;
            judgement_q   <= judgement_d;
            judge_lane_q  <= judge_lane_d;
            score_q       <= score_d;
            combo_q       <= combo_d;
            max_combo_q   <= max_combo_d;
            overrun_q     <= overrun_d;
        end
    end
    assign bus.note_clear  = note_clear_q;
    assign bus.judge_valid = judge_valid_q;
    assign bus.judgement   = judgement_q;
    assign bus.judge_lane  = judge_lane_q;
    assign bus.score       = score_q;
    assign bus.combo       = combo_q;
    assign bus.max_combo   = max_combo_q;
    assign bus.busy        = state_q == EVAL;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: frame-level reference model of the hit judge; a second instance with a huge
// PERFECT_PTS exercises score saturation without thousands of frames.
module tb_hit_judge;
    localparam int TY = 54, PW = 4, GW = 12;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0, errors = 0;
    logic [3:0] m_acc, m_held;
    int m_score, m_score2, m_combo, m_max, m_jud, m_lane;
    bit m_over;
    hit_judge_if bus();
    hit_judge_if sbus();
    hit_judge dut (.Clk(clk), .Reset(reset), .bus(bus));
    hit_judge #(.PERFECT_PTS(32767)) sat (.Clk(clk), .Reset(reset), .bus(sbus));
    assign sbus.frame_clk  = bus.frame_clk;
    assign sbus.key_press  = bus.key_press;
    assign sbus.note_valid = bus.note_valid;
    assign sbus.note_y     = bus.note_y;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.frame_clk = 1'b0;
        bus.key_press = '0;
        bus.note_valid = '0;
        bus.note_y = '0;
        step;
        step;
        reset = 1'b0;
        m_acc = '0; m_held = '0; m_score = 0; m_score2 = 0;
        m_combo = 0; m_max = 0; m_jud = 0; m_lane = 0; m_over = 0;
    endtask

    function automatic logic [39:0] pack(int y0, int y1, int y2, int y3);
        return {10'(y3), 10'(y2), 10'(y1), 10'(y0)};
    endfunction

    function automatic int judge(int i, logic [3:0] np, logic [3:0] nv, logic [39:0] ny);
        int y, d;
        y = int'(ny[i*10 +: 10]);
        d = y > TY ? y - TY : TY - y;
        if (nv[i] && y + GW < TY) return 3;
        if (np[i] && nv[i] && d <= PW) return 1;
        if (np[i] && nv[i] && d <= GW) return 2;
        return 0;
    endfunction

    // One frame: mid-frame press pm, tick-cycle press pt, optional tick during EVAL with press po.
    task automatic frame(input logic [3:0] pm, input logic [3:0] pt, input logic [3:0] nv,
                         input logic [39:0] ny, input bit ovr, input logic [3:0] po);
        logic [3:0] np;
        int j;
        bus.note_valid = nv;
        bus.note_y = ny;
        bus.key_press = pm;
        step;
        m_acc |= pm;
        bus.key_press = '0;
        step;
        bus.frame_clk = 1'b1;
        bus.key_press = pt;
        step;
        np = m_acc & ~m_held;
        m_held = m_acc;
        m_acc = pt;
        bus.frame_clk = 1'b0;
        bus.key_press = '0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_tick: got %b want 1", bus.busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (ovr && i == 1) begin
                bus.frame_clk = 1'b1;
                bus.key_press = po;
                m_acc |= po;
                m_over = 1;
            end
            if (ovr && i == 2) begin
                bus.frame_clk = 1'b0;
                bus.key_press = '0;
            end
            step;
            j = judge(i, np, nv, ny);
            if (j != 0) begin
                m_jud = j;
                m_lane = i;
                if (j == 3) m_combo = 0;
                else begin
                    m_score  = m_score + (j == 1 ? 2 : 1);
                    m_score  = m_score > 65535 ? 65535 : m_score;
                    m_score2 = m_score2 + (j == 1 ? 32767 : 1);
                    m_score2 = m_score2 > 65535 ? 65535 : m_score2;
                    m_combo  = m_combo == 1023 ? 1023 : m_combo + 1;
                    m_max    = m_combo > m_max ? m_combo : m_max;
                end
            end
            checks++;
            if (bus.judge_valid !== (j != 0) || bus.note_clear !== (j != 0 ? 4'(1 << i) : 4'b0) ||
                sbus.judge_valid !== (j != 0) || bus.judgement !== 2'(m_jud) || bus.judge_lane !== 2'(m_lane) ||
                bus.score !== 16'(m_score) || sbus.score !== 16'(m_score2) || bus.combo !== 10'(m_combo) ||
                bus.max_combo !== 10'(m_max) || bus.busy !== (i < 3) || bus.overrun !== m_over) begin
                errors++;
                $display("FAIL lane%0d_event: got v=%b clr=%b j=%0d l=%0d s=%0d s2=%0d c=%0d mc=%0d busy=%b ovr=%b; want v=%b j=%0d l=%0d s=%0d s2=%0d c=%0d mc=%0d busy=%b ovr=%b",
                         i, bus.judge_valid, bus.note_clear, bus.judgement, bus.judge_lane, bus.score, sbus.score,
                         bus.combo, bus.max_combo, bus.busy, bus.overrun, j != 0, m_jud, m_lane, m_score, m_score2,
                         m_combo, m_max, i < 3, m_over);
            end
        end
    endtask

    task automatic test_reset;
        int pulses;
        do_reset;
        checks++;
        if (bus.note_clear !== 0 || bus.judge_valid !== 0 || bus.judgement !== 0 || bus.judge_lane !== 0 ||
            bus.score !== 0 || bus.combo !== 0 || bus.max_combo !== 0 || bus.busy !== 0 || bus.overrun !== 0 ||
            sbus.score !== 0) begin
            errors++;
            $display("FAIL reset_values: got clr=%b v=%b j=%0d l=%0d s=%0d c=%0d mc=%0d busy=%b ovr=%b s2=%0d; want all 0",
                     bus.note_clear, bus.judge_valid, bus.judgement, bus.judge_lane, bus.score, bus.combo,
                     bus.max_combo, bus.busy, bus.overrun, sbus.score);
        end
        bus.note_valid = 4'b0100;
        bus.note_y = pack(54, 54, 54, 54);
        bus.key_press = 4'b0100;
        step;
        bus.key_press = '0;
        step;
        bus.frame_clk = 1'b1;
        step;
        bus.frame_clk = 1'b0;
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.judge_valid === 1'b1 || bus.note_clear !== 4'b0) pulses++;
            step;
        end
        checks++;
        if (pulses !== 0 || bus.score !== 16'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_eval: got pulses=%0d score=%0d busy=%b; want 0 0 0", pulses, bus.score, bus.busy);
        end
        do_reset;
    endtask

    task automatic test_perfect;
        frame(4'b0100, 4'b0, 4'b0100, pack(0, 0, 56, 0), 0, 4'b0);
        checks++;
        if (bus.judgement !== 2'd1 || bus.judge_lane !== 2'd2 || bus.score !== 16'd2 || bus.combo !== 10'd1) begin
            errors++;
            $display("FAIL perfect_lane2: got j=%0d l=%0d s=%0d c=%0d; want 1 2 2 1",
                     bus.judgement, bus.judge_lane, bus.score, bus.combo);
        end
    endtask

    task automatic test_good_held;
        logic [39:0] ny;
        ny = pack(44, 0, 0, 0);
        frame(4'b0001, 4'b0, 4'b0001, ny, 0, 4'b0);
        checks++;
        if (bus.judgement !== 2'd2 || bus.judge_lane !== 2'd0 || bus.score !== 16'd3 || bus.combo !== 10'd2) begin
            errors++;
            $display("FAIL good_lane0: got j=%0d l=%0d s=%0d c=%0d; want 2 0 3 2",
                     bus.judgement, bus.judge_lane, bus.score, bus.combo);
        end
        frame(4'b0001, 4'b0, 4'b0001, ny, 0, 4'b0);
        frame(4'b0000, 4'b0, 4'b0001, ny, 0, 4'b0);
        frame(4'b0000, 4'b0001, 4'b0001, ny, 0, 4'b0);
        checks++;
        if (bus.score !== 16'd3 || bus.combo !== 10'd2) begin
            errors++;
            $display("FAIL held_no_event: got s=%0d c=%0d; want 3 2", bus.score, bus.combo);
        end
        frame(4'b0000, 4'b0, 4'b0001, ny, 0, 4'b0);
        checks++;
        if (bus.score !== 16'd4 || bus.combo !== 10'd3 || bus.judgement !== 2'd2) begin
            errors++;
            $display("FAIL tick_cycle_press: got s=%0d c=%0d j=%0d; want 4 3 2", bus.score, bus.combo, bus.judgement);
        end
    endtask

    task automatic test_miss;
        do_reset;
        frame(4'b1111, 4'b0, 4'b1111, pack(54, 54, 54, 54), 0, 4'b0);
        frame(4'b0000, 4'b0, 4'b0000, pack(54, 54, 54, 54), 0, 4'b0);
        frame(4'b0001, 4'b0, 4'b0001, pack(54, 54, 54, 54), 0, 4'b0);
        frame(4'b0010, 4'b0, 4'b1010, pack(0, 100, 0, 40), 0, 4'b0);
        checks++;
        if (bus.judgement !== 2'd3 || bus.judge_lane !== 2'd3 || bus.combo !== 10'd0 ||
            bus.max_combo !== 10'd5 || bus.score !== 16'd10) begin
            errors++;
            $display("FAIL miss_lane3: got j=%0d l=%0d c=%0d mc=%0d s=%0d; want 3 3 0 5 10",
                     bus.judgement, bus.judge_lane, bus.combo, bus.max_combo, bus.score);
        end
    endtask

    task automatic test_all_lanes;
        frame(4'b0000, 4'b0, 4'b0000, '0, 0, 4'b0);
        frame(4'b1111, 4'b0, 4'b1111, pack(54, 54, 54, 54), 0, 4'b0);
        checks++;
        if (bus.score !== 16'd18 || bus.combo !== 10'd4 || bus.judge_lane !== 2'd3) begin
            errors++;
            $display("FAIL all_lanes: got s=%0d c=%0d l=%0d; want 18 4 3", bus.score, bus.combo, bus.judge_lane);
        end
    endtask

    task automatic test_overrun;
        frame(4'b0000, 4'b0, 4'b0100, pack(54, 54, 54, 54), 1, 4'b0100);
        checks++;
        if (bus.overrun !== 1'b1 || bus.score !== 16'd18) begin
            errors++;
            $display("FAIL overrun_set: got ovr=%b s=%0d; want 1 18", bus.overrun, bus.score);
        end
        frame(4'b0000, 4'b0, 4'b0100, pack(54, 54, 54, 54), 0, 4'b0);
        checks++;
        if (bus.overrun !== 1'b1 || bus.score !== 16'd20 || bus.judge_lane !== 2'd2) begin
            errors++;
            $display("FAIL overrun_press_kept: got ovr=%b s=%0d l=%0d; want 1 20 2", bus.overrun, bus.score, bus.judge_lane);
        end
    endtask

    task automatic test_random;
        logic [39:0] ny;
        for (int f = 0; f < 150; f++) begin
            for (int i = 0; i < 4; i++)
                ny[i*10 +: 10] = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(30, 80));
            frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ny,
                  $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_saturation;
        logic [39:0] ny;
        ny = pack(54, 54, 54, 54);
        do_reset;
        frame(4'b0001, 4'b0, 4'b1111, ny, 0, 4'b0);
        frame(4'b0010, 4'b0, 4'b1111, ny, 0, 4'b0);
        checks++;
        if (sbus.score !== 16'hFFFE) begin
            errors++;
            $display("FAIL score_fffe: got %h want fffe", sbus.score);
        end
        frame(4'b0100, 4'b0, 4'b1111, ny, 0, 4'b0);
        frame(4'b1000, 4'b0, 4'b1111, ny, 0, 4'b0);
        checks++;
        if (sbus.score !== 16'hFFFF) begin
            errors++;
            $display("FAIL score_sat: got %h want ffff", sbus.score);
        end
        for (int k = 0; k < 512; k++)
            frame(k % 2 == 0 ? 4'b0011 : 4'b1100, 4'b0, 4'b1111, ny, 0, 4'b0);
        checks++;
        if (bus.combo !== 10'd1023 || bus.max_combo !== 10'd1023) begin
            errors++;
            $display("FAIL combo_reach_sat: got c=%0d mc=%0d; want 1023 1023", bus.combo, bus.max_combo);
        end
        frame(4'b0001, 4'b0, 4'b0001, pack(44, 0, 0, 0), 0, 4'b0);
        checks++;
        if (bus.judgement !== 2'd2 || bus.combo !== 10'd1023 || bus.max_combo !== 10'd1023) begin
            errors++;
            $display("FAIL combo_sat_good: got j=%0d c=%0d mc=%0d; want 2 1023 1023",
                     bus.judgement, bus.combo, bus.max_combo);
        end
    endtask

    initial begin
        test_reset;
        test_perfect;
        test_good_held;
        test_miss;
        test_all_lanes;
        test_overrun;
        test_random;
        test_saturation;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
